// File: rtl/div_iter_unit.sv
// Radix-2 restoring DIV/DIVU that produces one quotient bit per cycle. Done pulses WIDTH+1 cycles after accept.
// Stalls E from the accept cycle until done; a cancel aborts the divide and leaves HI/LO unchanged.
module div_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_E,
  input  logic             signed_E,
  input  logic [WIDTH-1:0] a_E,
  input  logic [WIDTH-1:0] b_E,
  input  logic             cancel_E,
  output logic             stall_div,
  output logic             done_E,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_a;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_dz;

  logic             w_accept;
  logic             w_last;
  logic             w_fin;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic [WIDTH-1:0] w_lo_fin;
  logic [WIDTH-1:0] w_hi_fin;

  assign w_accept = (r_state == S_IDLE) && start_E && !cancel_E;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_fin    = (r_state == S_DIV) && (w_state_nxt == S_DONE);

  // The shifted partial remainder needs one extra bit: it can exceed the divisor's range.
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_ge      = (w_shift >= {1'b0, r_div});
  assign w_rem_nxt = w_ge ? (w_shift[WIDTH-1:0] - r_div) : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

  assign w_a_abs  = (signed_E && a_E[WIDTH-1]) ? -a_E : a_E;
  assign w_b_abs  = (signed_E && b_E[WIDTH-1]) ? -b_E : b_E;
  assign w_lo_fin = r_dz ? {WIDTH{1'b1}} : (r_qneg ? -w_quo_nxt : w_quo_nxt);
  assign w_hi_fin = r_dz ? r_a : (r_rneg ? -w_rem_nxt : w_rem_nxt);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_DIV;
      S_DIV:   begin
        if (cancel_E)    w_state_nxt = S_IDLE;
        else if (w_last) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    stall_div = w_accept || (r_state == S_DIV);
    done_E    = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_a    <= '0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_dz   <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      if (w_accept) begin
        r_cnt  <= '0;
        r_rem  <= '0;
        r_quo  <= w_a_abs;
        r_div  <= w_b_abs;
        r_a    <= a_E;
        r_qneg <= signed_E && (a_E[WIDTH-1] ^ b_E[WIDTH-1]);
        r_rneg <= signed_E && a_E[WIDTH-1];
        r_dz   <= (b_E == '0);
      end else if (r_state == S_DIV && !cancel_E) begin
        r_cnt <= r_cnt + 1'b1;
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
      end
      if (w_fin) begin
        lo_out <= w_lo_fin;
        hi_out <= w_hi_fin;
      end
    end
  end

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed bench for div_iter_unit: vector table plus cancel, reset and back-to-back sequences.
module tb_div_iter_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_E;
  logic         signed_E;
  logic [W-1:0] a_E;
  logic [W-1:0] b_E;
  logic         cancel_E;
  logic         stall_div;
  logic         done_E;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
  } vec_t;

  vec_t vecs[10];

  div_iter_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_E  (start_E),
    .signed_E (signed_E),
    .a_E      (a_E),
    .b_E      (b_E),
    .cancel_E (cancel_E),
    .stall_div(stall_div),
    .done_E   (done_E),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Present a request in a fresh cycle T and hold it; report the cycle offset of done_E
  // (-1 if it never came) and how many cycles stall_div differed from "high T..T+W".
  task automatic run_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int done_at, output int stall_bad);
    @(posedge clk); #1;
    start_E  = 1'b1;
    signed_E = sgn;
    a_E      = a;
    b_E      = b;
    done_at   = -1;
    stall_bad = 0;
    for (int n = 0; n < W + 8; n++) begin
      @(negedge clk);
      if (stall_div !== (n <= W)) stall_bad++;
      if (done_E === 1'b1) begin
        done_at = n;
        break;
      end
    end
  endtask

  task automatic end_div(input string name);
    @(posedge clk); #1;
    start_E = 1'b0;
    @(negedge clk);
    chk({name, "_done_once"}, {31'd0, done_E}, 32'd0);
  endtask

  task automatic check_run(input string name, input logic sgn, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] lo, input logic [W-1:0] hi);
    int d;
    int s;
    run_div(sgn, a, b, d, s);
    chk({name, "_latency"}, d, 32'd33);
    chk({name, "_stall"}, s, 32'd0);
    chk({name, "_lo"}, lo_out, lo);
    chk({name, "_hi"}, hi_out, hi);
  endtask

  initial begin
    int d;
    int s;
    bit seen_done;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
    vecs[3] = '{1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678};
    vecs[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    vecs[5] = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB};
    vecs[6] = '{1'b0, 32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF};
    vecs[7] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE};
    vecs[8] = '{1'b0, 32'd5,          32'd9,          32'd0,          32'd5};
    vecs[9] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};

    rst      = 1'b1;
    start_E  = 1'b0;
    signed_E = 1'b0;
    a_E      = '0;
    b_E      = '0;
    cancel_E = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_done",  {31'd0, done_E},    32'd0);
    chk("reset_stall", {31'd0, stall_div}, 32'd0);
    chk("reset_lo", lo_out, 32'd0);
    chk("reset_hi", hi_out, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      check_run($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi);
      end_div($sformatf("vec%0d", i));
    end

    // Cancel in the middle of DIV 50/5; the 100/7 result must survive.
    check_run("pre_cancel", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    end_div("pre_cancel");
    @(posedge clk); #1;
    start_E = 1'b1; signed_E = 1'b1; a_E = 32'd50; b_E = 32'd5;
    seen_done = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (done_E) seen_done = 1'b1;
      if (n < 9) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    cancel_E = 1'b1;
    @(negedge clk);
    chk("cancel_stall_T10", {31'd0, stall_div}, 32'd1);
    if (done_E) seen_done = 1'b1;
    @(posedge clk); #1;
    cancel_E = 1'b0;
    start_E  = 1'b0;
    @(negedge clk);
    chk("cancel_stall_T11", {31'd0, stall_div}, 32'd0);
    if (done_E) seen_done = 1'b1;
    chk("cancel_no_done", {31'd0, seen_done}, 32'd0);
    chk("cancel_lo_kept", lo_out, 32'd14);
    chk("cancel_hi_kept", hi_out, 32'd2);
    check_run("after_cancel", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1);
    end_div("after_cancel");

    // Start with cancel asserted in IDLE is not accepted.
    @(posedge clk); #1;
    start_E = 1'b1; cancel_E = 1'b1; signed_E = 1'b0; a_E = 32'd77; b_E = 32'd3;
    @(negedge clk);
    chk("idle_cancel_stall", {31'd0, stall_div}, 32'd0);
    @(posedge clk); #1;
    start_E = 1'b0; cancel_E = 1'b0;
    @(negedge clk);
    chk("idle_cancel_not_started", {31'd0, stall_div}, 32'd0);
    repeat (W + 2) @(posedge clk);
    @(negedge clk);
    chk("idle_cancel_lo", lo_out, 32'd2);

    // Reset at T+5 mid-divide.
    @(posedge clk); #1;
    start_E = 1'b1; signed_E = 1'b0; a_E = 32'd100; b_E = 32'd7;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    start_E = 1'b0;
    @(negedge clk);
    chk("rst_mid_stall_before", {31'd0, stall_div}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_done",  {31'd0, done_E},    32'd0);
    chk("rst_mid_stall", {31'd0, stall_div}, 32'd0);
    chk("rst_mid_lo", lo_out, 32'd0);
    chk("rst_mid_hi", hi_out, 32'd0);

    // Back-to-back with start_E held through DONE.
    run_div(1'b0, 32'd20, 32'd3, d, s);
    chk("b2b1_latency", d, 32'd33);
    chk("b2b1_stall", s, 32'd0);
    chk("b2b1_lo", lo_out, 32'd6);
    chk("b2b1_hi", hi_out, 32'd2);
    run_div(1'b0, 32'd1000, 32'd10, d, s);
    chk("b2b2_latency", d, 32'd33);
    chk("b2b2_stall", s, 32'd0);
    chk("b2b2_lo", lo_out, 32'd100);
    chk("b2b2_hi", hi_out, 32'd0);
    end_div("b2b2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
